// File: rtl/fp_norm_round.sv
// Normalize-and-round stage of the single-precision FP adder.
// Renormalizes one bit per cycle, rounds to nearest-even and packs a binary32 result.
module fp_norm_round (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [24:0] sum_i,
   input  logic [7:0]  exp_i,
   input  logic        sign_i,
   input  logic [2:0]  grs_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] result_o,
   output logic [3:0]  flags_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] NORM  = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state;
   logic [24:0] sig;
   logic [8:0]  exp;
   logic        sgn;
   logic        g, r, s;

   function automatic logic rne_inc(input logic gb, input logic rb, input logic sb, input logic lsb);
      return gb & (rb | sb | lsb);
   endfunction

   logic [24:0] sig_inc, sig_rnd;
   logic [8:0]  exp_rnd;
   logic [7:0]  exp_fld;
   logic        inexact;
   logic [31:0] rnd_result;
   logic [3:0]  rnd_flags;

   always_comb begin
      sig_inc    = sig + {24'd0, rne_inc(g, r, s, sig[0])};
      sig_rnd    = sig_inc;
      exp_rnd    = exp;
      inexact    = g | r | s;
      exp_fld    = 8'h00;
      rnd_result = 32'h0;
      rnd_flags  = 4'h0;
      if (sig_inc[24]) begin
         sig_rnd = sig_inc >> 1;
         exp_rnd = exp + 9'd1;
      end
      if (exp_rnd >= 9'd255) begin
         rnd_result = {sgn, 8'hFF, 23'h0};
         rnd_flags  = 4'b1010;
      end else begin
         // Missing hidden bit means a subnormal: exponent field forced to 0.
         exp_fld    = sig_rnd[23] ? exp_rnd[7:0] : 8'h00;
         rnd_result = {sgn, exp_fld, sig_rnd[22:0]};
         rnd_flags  = {1'b0, (exp_fld == 8'h00) & inexact, inexact, 1'b0};
      end
   end

   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == DONE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         sig      <= 25'd0;
         exp      <= 9'd0;
         sgn      <= 1'b0;
         g        <= 1'b0;
         r        <= 1'b0;
         s        <= 1'b0;
         result_o <= 32'h0;
         flags_o  <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  sig   <= sum_i;
                  exp   <= {1'b0, exp_i};
                  sgn   <= sign_i;
                  {g, r, s} <= grs_i;
                  state <= NORM;
               end
            end
            NORM: begin
               if (sig == 25'd0 && !(g | r | s)) begin
                  result_o <= 32'h0;
                  flags_o  <= 4'b0001;
                  state    <= DONE;
               end else if (sig[24]) begin
                  // Carry shift counts as a normalization cycle; the next pass sees bit 23 set.
                  sig <= sig >> 1;
                  g   <= sig[0];
                  r   <= g;
                  s   <= r | s;
                  exp <= exp + 9'd1;
               end else if (!sig[23] && exp > 9'd1) begin
                  sig <= {sig[23:0], g};
                  g   <= r;
                  r   <= 1'b0;
                  exp <= exp - 9'd1;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               result_o <= rnd_result;
               flags_o  <= rnd_flags;
               state    <= DONE;
            end
            default: begin
               if (out_ready_i) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: table of vectors plus backpressure and mid-operation reset sequences.
module tb_fp_norm_round;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [24:0] sum_i = 25'd0;
   logic [7:0]  exp_i = 8'd0;
   logic        sign_i = 1'b0;
   logic [2:0]  grs_i = 3'd0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] result_o;
   logic [3:0]  flags_o;

   int n_cmp = 0;
   int n_bad = 0;

   fp_norm_round dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .sum_i(sum_i), .exp_i(exp_i), .sign_i(sign_i), .grs_i(grs_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .result_o(result_o), .flags_o(flags_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [24:0] sum;
      logic [7:0]  exp;
      logic        sign;
      logic [2:0]  grs;
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Drive one operand, return the latency and leave the DUT sitting in DONE.
   task automatic issue(input logic [24:0] sum, input logic [7:0] e, input logic sg,
                        input logic [2:0] grs, output int lat);
      @(negedge clk_i);
      sum_i = sum; exp_i = e; sign_i = sg; grs_i = grs; in_valid_i = 1'b1;
      #1;
      check("in_ready_idle", {31'd0, in_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      lat = 0;
      while (!out_valid_o && lat < 40) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      @(negedge clk_i);
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      check("valid_after_xfer", {31'd0, out_valid_o}, 32'd0);
      check("ready_after_xfer", {31'd0, in_ready_o}, 32'd1);
   endtask

   initial begin
      int lat;
      int seen;

      vecs[0] = '{"carry",     25'h1000000, 8'd127, 1'b0, 3'b000, 32'h40000000, 4'b0000, 3};
      vecs[1] = '{"normal",    25'h0C00000, 8'd127, 1'b0, 3'b000, 32'h3FC00000, 4'b0000, 2};
      vecs[2] = '{"cancel",    25'h0000001, 8'd127, 1'b0, 3'b000, 32'h34000000, 4'b0000, 25};
      vecs[3] = '{"subnormal", 25'h0100000, 8'd3,   1'b0, 3'b000, 32'h00400000, 4'b0000, 4};
      vecs[4] = '{"tie_odd",   25'h0800001, 8'd127, 1'b0, 3'b100, 32'h3F800002, 4'b0010, 2};
      vecs[5] = '{"tie_even",  25'h0800000, 8'd127, 1'b0, 3'b100, 32'h3F800000, 4'b0010, 2};
      vecs[6] = '{"overflow",  25'h1FFFFFE, 8'd254, 1'b1, 3'b000, 32'hFF800000, 4'b1010, 3};
      vecs[7] = '{"zero",      25'h0000000, 8'd100, 1'b1, 3'b000, 32'h00000000, 4'b0001, 1};

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_in_ready",  {31'd0, in_ready_o},  32'd1);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_result",    result_o,             32'h0);
      check("rst_flags",     {28'd0, flags_o},     32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].sum, vecs[i].exp, vecs[i].sign, vecs[i].grs, lat);
         check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
         check({vecs[i].name, "_result"}, result_o, vecs[i].res);
         check({vecs[i].name, "_flags"}, {28'd0, flags_o}, {28'd0, vecs[i].flg});
         drain();
      end

      // Backpressure: result held and new operands refused while waiting in DONE.
      issue(25'h1FFFFFE, 8'd254, 1'b1, 3'b000, lat);
      check("bp_latency", lat, 3);
      @(negedge clk_i);
      sum_i = 25'h0C00000; exp_i = 8'd127; sign_i = 1'b0; grs_i = 3'b000; in_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk_i);
         #1;
         check("bp_valid",    {31'd0, out_valid_o}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready_o},  32'd0);
         check("bp_result",   result_o,             32'hFF800000);
         check("bp_flags",    {28'd0, flags_o},     32'h0000000A);
      end
      in_valid_i = 1'b0;
      drain();

      // Reset in the middle of a long cancellation shift sequence.
      issue(25'h0000001, 8'd127, 1'b0, 3'b000, lat);
      drain();
      issue(25'h0000001, 8'd127, 1'b0, 3'b000, lat);
      drain();
      @(negedge clk_i);
      sum_i = 25'h0000001; exp_i = 8'd127; in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      repeat (6) @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check("midrst_in_ready",  {31'd0, in_ready_o},  32'd1);
      check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("midrst_result",    result_o,             32'h0);
      check("midrst_flags",     {28'd0, flags_o},     32'h0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk_i);
         #1;
         if (out_valid_o) seen++;
      end
      check("midrst_no_output", seen, 0);

      issue(25'h0C00000, 8'd127, 1'b0, 3'b000, lat);
      check("post_rst_latency", lat, 2);
      check("post_rst_result", result_o, 32'h3FC00000);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
